video_capture: RTL and testbench

VIDEO_CAPTURE -- requirements
Module: video_capture

---
 rtl/video_pkg.sv | 29 ++
 rtl/plane_packer.sv | 43 ++++
 rtl/video_capture.sv | 135 +++++++++++++
 tb/tb_video_capture.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared state encoding, frame geometry constants and the CRC-16-CCITT helper for video_capture.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int PIX_PER_WORD    = 8;
  localparam int WORDS_PER_LINE  = 32;
  localparam int LINES_PER_FRAME = 256;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Bit-serial CCITT update over one word, bit 31 first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/plane_packer.sv
// Four-plane shifter: collects 8 serial colour indices and emits one packed 32-bit planar word.
module plane_packer
  import video_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [3:0]  idx,
  input  logic        shift_en,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [3:0][6:0] hist;
  logic [3:0][7:0] next_planes;
  logic [2:0]      cnt;

  // The word is formed from history plus the incoming pixel so it is ready in the 8th pixel's cycle.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      next_planes[n] = {hist[n], idx[n]};
    end
  end

  assign word       = {next_planes[0], next_planes[1], next_planes[2], next_planes[3]};
  assign word_valid = shift_en && (cnt == 3'(PIX_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      cnt  <= '0;
    end else if (clear) begin
      hist <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      for (int n = 0; n < 4; n++) begin
        hist[n] <= next_planes[n][6:0];
      end
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/video_capture.sv
// Frame grabber that packs serial colour indices into 4-plane VRAM words.
// Optional CRC over accepted words is built when VIDEO_CAPTURE_CRC_EN is defined.
module video_capture
  import video_pkg::*;
#(
  parameter logic [9:0] H_START = 10'd0,
  parameter logic [8:0] V_START = 9'd0
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [3:0]  idx_in,
  input  logic        arm,
  output logic [12:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] crc,
  output state_t      state
);

  state_t      state_next;
  logic        hs_d, vs_d, hs_fall, vs_rise;
  logic [9:0]  pix_cnt, pix_off;
  logic [8:0]  line_cnt, line_off;
  logic        active, arm_ok;
  logic [31:0] word;
  logic        word_valid, word_last, held_last;
  logic [12:0] word_addr;
  logic        accept, drop, load;

  assign hs_fall = hs_d & ~hs_in;
  assign vs_rise = vs_in & ~vs_d;
  assign arm_ok  = arm && (state == IDLE || state == DONE);

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      hs_d <= hs_in;
      vs_d <= vs_in;
      if (hs_fall)                      pix_cnt <= '0;
      else if (ce_pix && pix_cnt != '1) pix_cnt <= pix_cnt + 10'd1;
      if (vs_rise)                         line_cnt <= '0;
      else if (hs_fall && line_cnt != '1)  line_cnt <= line_cnt + 9'd1;
    end
  end

  // Offsets are compared as differences so a window near the counter top cannot wrap.
  assign pix_off  = pix_cnt - H_START;
  assign line_off = line_cnt - V_START;
  assign active   = ce_pix && (state == CAPTURE) &&
                    (pix_cnt >= H_START) && (pix_off < 10'd256) &&
                    (line_cnt >= V_START) && (line_off < 9'd256);

  plane_packer u_packer (
    .clk        (clk_pix),
    .rst        (reset),
    .clear      (arm_ok),
    .idx        (idx_in),
    .shift_en   (active),
    .word       (word),
    .word_valid (word_valid)
  );

  assign word_addr = {pix_off[7:3], ~line_off[7:0]};
  assign word_last = (pix_off[7:3] == 5'(WORDS_PER_LINE - 1)) &&
                     (line_off[7:0] == 8'(LINES_PER_FRAME - 1));

  // Write handshake: a word transfers on a cycle where mem_req and mem_ack are both high;
  // mem_addr/mem_data hold steady while mem_req is high and not yet acked.
  assign accept = mem_req && mem_ack;
  assign drop   = word_valid && mem_req && !mem_ack;
  assign load   = word_valid && !drop;

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      held_last <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (arm_ok)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (load) begin
        mem_req   <= 1'b1;
        mem_addr  <= word_addr;
        mem_data  <= word;
        held_last <= word_last;
      end else if (accept) begin
        mem_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm_ok) state_next = WAIT_VS;
      WAIT_VS: if (vs_rise) state_next = CAPTURE;
      // A dropped final word still ends the frame, otherwise capture would never finish.
      CAPTURE: if ((accept && held_last) || (drop && word_last)) state_next = DONE;
      DONE:    if (arm_ok) state_next = WAIT_VS;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == WAIT_VS) || (state == CAPTURE);
  assign done = (state == DONE);

`ifdef VIDEO_CAPTURE_CRC_EN
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset)       crc <= 16'h0000;
    else if (arm_ok) crc <= CRC_INIT;
    else if (accept) crc <= crc16_word(crc, mem_data);
  end
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: stimulus pushes expected writes, a monitor pops and compares accepted writes.
`timescale 1ns/1ps
module tb_video_capture;
  import video_pkg::*;

  logic        clk_pix = 1'b0;
  logic        reset, ce_pix, hs_in, vs_in, arm, mem_ack;
  logic [3:0]  idx_in;
  logic [12:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_req, busy, done, overflow;
  logic [15:0] crc;
  state_t      state;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int acc_count = 0;
  int acc_cyc[$];
  logic [44:0] exp_q[$];
  int ack_delay = 0;
  int ack_delay_next = 0;
  int age = 0;
  logic [3:0] line0_pix [256];
  logic [3:0] fill_idx;
  logic [31:0] frame_word;

  video_capture dut (
    .clk_pix  (clk_pix),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .idx_in   (idx_in),
    .arm      (arm),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .crc      (crc),
    .state    (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ {w[b*8 +: 8], 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step_sync(input logic hs, input logic vs);
    @(posedge clk_pix); #1;
    ce_pix = 1'b0; idx_in = 4'h0; arm = 1'b0; hs_in = hs; vs_in = vs;
  endtask

  task automatic pixel(input logic [3:0] v);
    @(posedge clk_pix); #1;
    ce_pix = 1'b1; idx_in = v; arm = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
  endtask

  task automatic arm_pulse();
    @(posedge clk_pix); #1;
    ce_pix = 1'b0; arm = 1'b1;
    @(posedge clk_pix); #1;
    arm = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk_pix); #1;
    reset = 1'b1; ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; arm = 1'b0; idx_in = 4'h0;
    repeat (2) @(posedge clk_pix);
    #1 reset = 1'b0;
  endtask

  // hs falls before vs rises so line 0 starts with the pixel counter at zero.
  task automatic frame_start();
    step_sync(1'b1, 1'b0);
    step_sync(1'b0, 1'b0);
    step_sync(1'b0, 1'b1);
    step_sync(1'b0, 1'b0);
  endtask

  task automatic drive_line0(input int npix);
    frame_start();
    for (int p = 0; p < npix; p++) pixel(line0_pix[p]);
    step_sync(1'b0, 1'b0);
  endtask

  task automatic drive_frame(input int abort_at, output bit aborted);
    int base;
    base = acc_count;
    aborted = 1'b0;
    frame_start();
    for (int l = 0; l < 256; l++) begin
      if (l > 0) begin
        step_sync(1'b1, 1'b0);
        step_sync(1'b0, 1'b0);
      end
      for (int c = 0; c < 32; c++) exp_q.push_back({5'(c), ~8'(l), frame_word});
      for (int p = 0; p < 256; p++) begin
        pixel(fill_idx);
        if (abort_at > 0 && (acc_count - base) >= abort_at) begin
          aborted = 1'b1;
          return;
        end
      end
    end
    step_sync(1'b0, 1'b0);
  endtask

  // ---------------- ack responder ----------------
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk_pix); #1;
      if (mem_req === 1'b1 && reset === 1'b0) begin
        mem_ack = (age >= ack_delay);
        if (mem_ack) begin
          age = 0;
          ack_delay = ack_delay_next;
        end else begin
          age++;
        end
      end else begin
        mem_ack = 1'b0;
        age = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [44:0] exp;
    forever begin
      @(negedge clk_pix);
      if (reset === 1'b0 && mem_req === 1'b1 && mem_ack === 1'b1) begin
        acc_count++;
        acc_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
        end else begin
          exp = exp_q.pop_front();
          check("write", {mem_addr, mem_data}, exp);
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int base;
    int req_seen;
    bit aborted;
    logic [15:0] exp_crc;

    reset = 1'b1; ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; arm = 1'b0; idx_in = 4'h0;
    repeat (3) @(posedge clk_pix);
    #1 reset = 1'b0;
    @(negedge clk_pix);
    check("reset_state", state, IDLE);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_mem_addr", mem_addr, 13'h0000);
    check("reset_mem_data", mem_data, 32'h0);
    check("reset_crc", crc, 16'h0000);

    // Test A: MSB placement, address layout, ack coincident with word completion
    for (int p = 0; p < 256; p++) line0_pix[p] = 4'h0;
    line0_pix[0] = 4'h1;
    line0_pix[8] = 4'h2;
    line0_pix[15] = 4'h8;
    for (int p = 16; p < 24; p++) line0_pix[p] = 4'h4;
    exp_q.push_back({13'h00FF, 32'h8000_0000});
    exp_q.push_back({13'h01FF, 32'h0080_0001});
    exp_q.push_back({13'h02FF, 32'h0000_FF00});
    ack_delay = 7; ack_delay_next = 0;
    acc_cyc.delete();
    base = acc_count;
    arm_pulse();
    @(negedge clk_pix);
    check("arm_state", state, WAIT_VS);
    check("arm_busy", busy, 1'b1);
`ifdef VIDEO_CAPTURE_CRC_EN
    check("arm_crc_init", crc, 16'hFFFF);
`else
    check("arm_crc_zero", crc, 16'h0000);
`endif
    drive_line0(24);
    repeat (12) @(posedge clk_pix);
    @(negedge clk_pix);
    check("a_write_count", acc_count - base, 3);
    if (acc_cyc.size() >= 2) check("a_no_gap", acc_cyc[1] - acc_cyc[0], 1);
    else check("a_no_gap_writes", acc_cyc.size(), 2);
    check("a_overflow", overflow, 1'b0);
    check("a_queue_empty", exp_q.size(), 0);
    arm_pulse();
    @(negedge clk_pix);
    check("arm_ignored_capture", state, CAPTURE);
    apply_reset();

    // Test B: 20-cycle stall on first word drops the two words that complete meanwhile
    for (int p = 0; p < 8; p++) line0_pix[p] = 4'h3;
    for (int p = 8; p < 24; p++) line0_pix[p] = 4'h1;
    for (int p = 24; p < 32; p++) line0_pix[p] = 4'h8;
    exp_q.push_back({13'h00FF, 32'hFFFF_0000});
    exp_q.push_back({13'h03FF, 32'h0000_00FF});
    ack_delay = 20; ack_delay_next = 0;
    base = acc_count;
    arm_pulse();
    drive_line0(32);
    repeat (30) @(posedge clk_pix);
    @(negedge clk_pix);
    check("b_write_count", acc_count - base, 2);
    check("b_overflow", overflow, 1'b1);
    check("b_queue_empty", exp_q.size(), 0);
    apply_reset();
    @(negedge clk_pix);
    check("b_reset_overflow", overflow, 1'b0);

    // Test C: reset mid-frame at word 100, then a full frame
`ifdef VIDEO_CAPTURE_CRC_EN
    fill_idx = 4'h0; frame_word = 32'h0000_0000;
`else
    fill_idx = 4'hF; frame_word = 32'hFFFF_FFFF;
`endif
    ack_delay = 0; ack_delay_next = 0;
    base = acc_count;
    arm_pulse();
    drive_frame(100, aborted);
    check("c_abort_reached", aborted, 1'b1);
    @(posedge clk_pix); #1;
    reset = 1'b1; ce_pix = 1'b0;
    @(negedge clk_pix);
    exp_q.delete();
    check("c_reset_mem_req", mem_req, 1'b0);
    check("c_reset_busy", busy, 1'b0);
    check("c_reset_state", state, IDLE);
    @(posedge clk_pix); #1 reset = 1'b0;
    req_seen = 0;
    repeat (10) begin
      @(negedge clk_pix);
      if (mem_req === 1'b1) req_seen++;
    end
    check("c_no_req_after_reset", req_seen, 0);

    base = acc_count;
    arm_pulse();
    drive_frame(0, aborted);
    for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk_pix);
    @(negedge clk_pix);
    check("full_done", done, 1'b1);
    check("full_write_count", acc_count - base, 8192);
    check("full_queue_empty", exp_q.size(), 0);
    check("full_overflow", overflow, 1'b0);
    check("full_busy", busy, 1'b0);
    check("full_state", state, DONE);
`ifdef VIDEO_CAPTURE_CRC_EN
    exp_crc = 16'hFFFF;
    for (int i = 0; i < 8192; i++) exp_crc = model_crc(exp_crc, frame_word);
    check("full_crc", crc, exp_crc);
`else
    exp_crc = 16'h0000;
    check("full_crc_zero", crc, exp_crc);
`endif
    arm_pulse();
    @(negedge clk_pix);
    check("rearm_done_clear", done, 1'b0);
    check("rearm_busy", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
